// File: rtl/fcn_output_stage.sv
// Output stage of the FCN PE array: banks final accumulators, applies bias, rounding shift,
// optional ReLU and saturation, then streams one channel per cycle over valid/ready.
module fcn_output_stage #(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned ACC_W  = 24,
  parameter int unsigned BIAS_W = 16,
  parameter int unsigned OUT_W  = 9,
  parameter int unsigned IDX_W  = $clog2(NUM_PE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       acc_valid,
  output logic                       acc_ready,
  input  logic [NUM_PE*ACC_W-1:0]    acc_data,
  input  logic [NUM_PE*BIAS_W-1:0]   bias_data,
  input  logic [4:0]                 shift,
  input  logic                       relu_en,
  output logic                       clr_acc,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_data,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last,
  output logic                       busy
);

  localparam int unsigned SUM_W = ACC_W + 2;
  localparam int unsigned SH_W  = 5;
  localparam logic signed [SUM_W-1:0] SAT_MAX = SUM_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_MIN = ~SAT_MAX;
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_PE - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EMIT} state_t;

  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_bank_q  [NUM_PE];
  logic [ACC_W-1:0]     acc_bank_d  [NUM_PE];
  logic [BIAS_W-1:0]    bias_bank_q [NUM_PE];
  logic [BIAS_W-1:0]    bias_bank_d [NUM_PE];
  logic [SH_W-1:0]      shift_q, shift_d;
  logic                 relu_q, relu_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_nxt;
  logic [OUT_W-1:0]     out_data_q, out_data_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic                 clr_acc_q, clr_acc_d;
  logic                 acc_ready_q, acc_ready_d;
  logic                 busy_q, busy_d;

  // Bias add, round-half-up arithmetic shift, ReLU and saturation for one lane.
  function automatic logic [OUT_W-1:0] lane_calc(
    input logic [ACC_W-1:0]  acc,
    input logic [BIAS_W-1:0] bias,
    input logic [SH_W-1:0]   sh,
    input logic              relu
  );
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] res;
    sum = $signed({{(SUM_W - ACC_W){acc[ACC_W-1]}}, acc})
        + $signed({{(SUM_W - BIAS_W){bias[BIAS_W-1]}}, bias});
    if (sh != '0) begin
      sum = sum + $signed(SUM_W'(1) << (sh - SH_W'(1)));
    end
    res = sum >>> sh;
    if (relu && res[SUM_W-1]) begin
      res = '0;
    end
    if (res > SAT_MAX) begin
      lane_calc = SAT_MAX[OUT_W-1:0];
    end else if (res < SAT_MIN) begin
      lane_calc = SAT_MIN[OUT_W-1:0];
    end else begin
      lane_calc = res[OUT_W-1:0];
    end
  endfunction

  always_comb begin
    state_d     = state_q;
    acc_bank_d  = acc_bank_q;
    bias_bank_d = bias_bank_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    idx_d       = idx_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    clr_acc_d   = 1'b0;
    acc_ready_d = acc_ready_q;
    busy_d      = busy_q;
    idx_nxt     = idx_q + IDX_W'(1);

    case (state_q)
      S_IDLE: begin
        if (acc_valid && acc_ready_q) begin
          for (int unsigned i = 0; i < NUM_PE; i++) begin
            acc_bank_d[i]  = acc_data[i*ACC_W +: ACC_W];
            bias_bank_d[i] = bias_data[i*BIAS_W +: BIAS_W];
          end
          // Shifts past the accumulator width collapse to the widest meaningful shift.
          shift_d     = (shift >= SH_W'(ACC_W)) ? SH_W'(ACC_W - 1) : shift;
          relu_d      = relu_en;
          idx_d       = '0;
          state_d     = S_LOAD;
          clr_acc_d   = 1'b1;
          acc_ready_d = 1'b0;
          busy_d      = 1'b1;
        end
      end
      S_LOAD: begin
        out_data_d  = lane_calc(acc_bank_q[0], bias_bank_q[0], shift_q, relu_q);
        idx_d       = '0;
        out_valid_d = 1'b1;
        out_last_d  = (NUM_PE == 1);
        state_d     = S_EMIT;
      end
      S_EMIT: begin
        if (out_ready) begin
          if (idx_q == IDX_LAST) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            acc_ready_d = 1'b1;
            busy_d      = 1'b0;
          end else begin
            idx_d      = idx_nxt;
            out_data_d = lane_calc(acc_bank_q[idx_nxt], bias_bank_q[idx_nxt], shift_q, relu_q);
            out_last_d = (idx_nxt == IDX_LAST);
          end
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
        acc_ready_d = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      for (int unsigned i = 0; i < NUM_PE; i++) begin
        acc_bank_q[i]  <= '0;
        bias_bank_q[i] <= '0;
      end
      shift_q     <= '0;
      relu_q      <= 1'b0;
      idx_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      clr_acc_q   <= 1'b0;
      acc_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_bank_q  <= acc_bank_d;
      bias_bank_q <= bias_bank_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      idx_q       <= idx_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      clr_acc_q   <= clr_acc_d;
      acc_ready_q <= acc_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign acc_ready = acc_ready_q;
  assign clr_acc   = clr_acc_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fcn_output_stage.sv
// Directed bench for fcn_output_stage: table of per-pass vectors plus handshake corner sequences.
module tb_fcn_output_stage;

  localparam int unsigned NUM_PE = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned BIAS_W = 16;
  localparam int unsigned OUT_W  = 9;
  localparam int unsigned IDX_W  = 3;
  localparam int          NV     = 5;

  typedef struct packed {
    logic [NUM_PE-1:0][ACC_W-1:0]  acc;
    logic [NUM_PE-1:0][BIAS_W-1:0] bias;
    logic [4:0]                    shift;
    logic                          relu;
    logic [NUM_PE-1:0][OUT_W-1:0]  exp;
  } vec_t;

  vec_t vecs [NV];

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     acc_valid;
  logic                     acc_ready;
  logic [NUM_PE*ACC_W-1:0]  acc_data;
  logic [NUM_PE*BIAS_W-1:0] bias_data;
  logic [4:0]               shift;
  logic                     relu_en;
  logic                     clr_acc;
  logic                     out_valid;
  logic                     out_ready;
  logic [OUT_W-1:0]         out_data;
  logic [IDX_W-1:0]         out_idx;
  logic                     out_last;
  logic                     busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fcn_output_stage dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .acc_valid (acc_valid),
    .acc_ready (acc_ready),
    .acc_data  (acc_data),
    .bias_data (bias_data),
    .shift     (shift),
    .relu_en   (relu_en),
    .clr_acc   (clr_acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .busy      (busy)
  );

  function automatic logic [NUM_PE-1:0][ACC_W-1:0] pa(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    pa = {ACC_W'(a7), ACC_W'(a6), ACC_W'(a5), ACC_W'(a4),
          ACC_W'(a3), ACC_W'(a2), ACC_W'(a1), ACC_W'(a0)};
  endfunction

  function automatic logic [NUM_PE-1:0][BIAS_W-1:0] pb(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    pb = {BIAS_W'(a7), BIAS_W'(a6), BIAS_W'(a5), BIAS_W'(a4),
          BIAS_W'(a3), BIAS_W'(a2), BIAS_W'(a1), BIAS_W'(a0)};
  endfunction

  function automatic logic [NUM_PE-1:0][OUT_W-1:0] pe(
    input int a0, input int a1, input int a2, input int a3,
    input int a4, input int a5, input int a6, input int a7);
    pe = {OUT_W'(a7), OUT_W'(a6), OUT_W'(a5), OUT_W'(a4),
          OUT_W'(a3), OUT_W'(a2), OUT_W'(a1), OUT_W'(a0)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic apply(input int v);
    acc_data  = vecs[v].acc;
    bias_data = vecs[v].bias;
    shift     = vecs[v].shift;
    relu_en   = vecs[v].relu;
    acc_valid = 1'b1;
  endtask

  task automatic scramble();
    for (int i = 0; i < 6; i++) acc_data[i*32 +: 32] = $urandom;
    for (int i = 0; i < 4; i++) bias_data[i*32 +: 32] = $urandom;
    shift   = 5'($urandom);
    relu_en = ~relu_en;
  endtask

  task automatic check_lane(input int v, input int ch, input string tag);
    chk($sformatf("%s ch%0d valid", tag, ch), int'(out_valid), 1);
    chk($sformatf("%s ch%0d data", tag, ch), int'($signed(out_data)), int'($signed(vecs[v].exp[ch])));
    chk($sformatf("%s ch%0d idx", tag, ch), int'(out_idx), ch);
    chk($sformatf("%s ch%0d last", tag, ch), int'(out_last), int'(ch == NUM_PE - 1));
    chk($sformatf("%s ch%0d clr", tag, ch), int'(clr_acc), 0);
    chk($sformatf("%s ch%0d acc_ready", tag, ch), int'(acc_ready), 0);
  endtask

  // Waits (bounded) for acc_ready, drives vector v, and checks the LOAD cycle.
  task automatic capture(input int v, input string tag, input bit hold);
    int n = 0;
    while (!acc_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " ready before capture"}, int'(acc_ready), 1);
    apply(v);
    @(negedge clk);
    chk({tag, " load clr"}, int'(clr_acc), 1);
    chk({tag, " load busy"}, int'(busy), 1);
    chk({tag, " load acc_ready"}, int'(acc_ready), 0);
    chk({tag, " load valid"}, int'(out_valid), 0);
    if (!hold) begin
      acc_valid = 1'b0;
      scramble();
    end
  endtask

  // Called at the LOAD-cycle negedge; streams all channels with optional stall.
  task automatic run_emit(input int v, input string tag, input int stall_ch, input int stall_len);
    out_ready = 1'b1;
    @(negedge clk);
    for (int ch = 0; ch < NUM_PE; ch++) begin
      check_lane(v, ch, tag);
      if (ch == stall_ch) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check_lane(v, ch, $sformatf("%s stall%0d", tag, s));
          scramble();
          acc_valid = 1'($urandom);
        end
        out_ready = 1'b1;
        acc_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk({tag, " end acc_ready"}, int'(acc_ready), 1);
    chk({tag, " end valid"}, int'(out_valid), 0);
    chk({tag, " end busy"}, int'(busy), 0);
    chk({tag, " end last"}, int'(out_last), 0);
    chk({tag, " end clr"}, int'(clr_acc), 0);
  endtask

  initial begin
    vecs[0].acc   = pa(1000, 12, -12, -13, 2044, -2060, 0, 20);
    vecs[0].bias  = pb(24, 0, 0, 0, 0, 0, -20, 0);
    vecs[0].shift = 5'd3;
    vecs[0].relu  = 1'b0;
    vecs[0].exp   = pe(128, 2, -1, -2, 255, -256, -2, 3);

    vecs[1].acc   = pa(-5000, 4000, 4072, -4096, -4112, 160, 8388607, -8388608);
    vecs[1].bias  = pb(0, 100, 0, 0, 0, -32, 32767, -32768);
    vecs[1].shift = 5'd4;
    vecs[1].relu  = 1'b0;
    vecs[1].exp   = pe(-256, 255, 255, -256, -256, 8, 255, -256);

    vecs[2].acc   = vecs[1].acc;
    vecs[2].bias  = vecs[1].bias;
    vecs[2].shift = 5'd4;
    vecs[2].relu  = 1'b1;
    vecs[2].exp   = pe(0, 255, 255, 0, 0, 8, 255, 0);

    vecs[3].acc   = pa(100000, -1, 255, 256, -256, -257, 7, 0);
    vecs[3].bias  = pb(0, 0, 0, 0, 0, 0, 3, -100);
    vecs[3].shift = 5'd0;
    vecs[3].relu  = 1'b0;
    vecs[3].exp   = pe(255, -1, 255, 255, -256, -256, 10, -100);

    vecs[4].acc   = pa(8388607, -8388608, 4194304, 4194303, -4194304, -4194305, 8388607, 0);
    vecs[4].bias  = pb(0, 0, 0, 0, 0, 0, 32767, 0);
    vecs[4].shift = 5'd31;
    vecs[4].relu  = 1'b0;
    vecs[4].exp   = pe(1, -1, 1, 0, 0, -1, 1, 0);

    rst_n     = 1'b0;
    acc_valid = 1'b0;
    acc_data  = '0;
    bias_data = '0;
    shift     = '0;
    relu_en   = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset acc_ready", int'(acc_ready), 1);
    chk("reset valid", int'(out_valid), 0);
    chk("reset clr", int'(clr_acc), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset last", int'(out_last), 0);
    chk("reset data", int'(out_data), 0);
    chk("reset idx", int'(out_idx), 0);
    rst_n     = 1'b1;
    out_ready = 1'b1;

    for (int v = 0; v < NV; v++) begin
      capture(v, $sformatf("vec%0d", v), 1'b0);
      run_emit(v, $sformatf("vec%0d", v), -1, 0);
    end

    // Backpressure at channel 3 with inputs churning.
    capture(1, "bp", 1'b0);
    run_emit(1, "bp", 3, 5);

    // Reset mid-pass at channel 4, then a clean pass.
    capture(3, "mrst", 1'b0);
    @(negedge clk);
    for (int ch = 0; ch < 4; ch++) begin
      check_lane(3, ch, "mrst");
      @(negedge clk);
    end
    check_lane(3, 4, "mrst");
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst valid", int'(out_valid), 0);
    chk("mrst acc_ready", int'(acc_ready), 1);
    chk("mrst data", int'(out_data), 0);
    chk("mrst idx", int'(out_idx), 0);
    chk("mrst clr", int'(clr_acc), 0);
    chk("mrst busy", int'(busy), 0);
    chk("mrst last", int'(out_last), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst idle clr", int'(clr_acc), 0);
    capture(4, "post", 1'b0);
    run_emit(4, "post", -1, 0);

    // Back-to-back: acc_valid stays high, second data set presented during first pass.
    capture(0, "b2b0", 1'b1);
    apply(2);
    run_emit(0, "b2b0", -1, 0);
    @(negedge clk);
    chk("b2b1 clr", int'(clr_acc), 1);
    chk("b2b1 busy", int'(busy), 1);
    chk("b2b1 acc_ready", int'(acc_ready), 0);
    acc_valid = 1'b0;
    run_emit(2, "b2b1", -1, 0);
    @(negedge clk);
    chk("final clr", int'(clr_acc), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fcn_output_stage.md
# fcn_output_stage

Downstream stage of the FCN PE array: captures the final 24-bit accumulators of all PEs when a dot-product pass completes, applies per-channel bias, rounding right-shift, optional ReLU and saturation to the 9-bit signed activation format, then streams the results out one channel per cycle over a valid/ready handshake. It also issues the PE `clr` pulse, so accumulators restart as soon as their contents are safely banked.

## Interface
- `NUM_PE`, 8, number of PE lanes (output channels) captured per pass
- `ACC_W`, 24, accumulator width from each PE (signed)
- `BIAS_W`, 16, per-channel bias width (signed)
- `OUT_W`, 9, output activation width (signed)
- `IDX_W`, `$clog2(NUM_PE)`, channel index width

- `clk`  in  1  sole clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `acc_valid`  in  1  accumulators on `acc_data` are final
- `acc_ready`  out  1  stage can capture (high only in IDLE)
- `acc_data`  in  NUM_PE*ACC_W  lane i at `[i*ACC_W +: ACC_W]`, signed
- `bias_data`  in  NUM_PE*BIAS_W  lane i at `[i*BIAS_W +: BIAS_W]`, signed
- `shift`  in  5  right-shift amount, sampled at capture
- `relu_en`  in  1  ReLU enable, sampled at capture
- `clr_acc`  out  1  one-cycle pulse to PE `clr`
- `out_valid`  out  1  `out_data` holds a valid activation
- `out_ready`  in  1  consumer accepts
- `out_data`  out  OUT_W  signed activation
- `out_idx`  out  IDX_W  channel of `out_data`
- `out_last`  out  1  high with final channel (idx NUM_PE-1)
- `busy`  out  1  high whenever not IDLE

## Operation
- States: IDLE, LOAD, EMIT.
- IDLE: `acc_ready`=1. On `acc_valid`&`acc_ready`: bank all `acc_data` and `bias_data` lanes, latch `shift` (values ≥ ACC_W clamp to ACC_W-1) and `relu_en`, index ← 0, go LOAD.
- LOAD (exactly one cycle): `clr_acc`=1; register lane 0 result into `out_data`, `out_idx`=0; go EMIT.
- EMIT: `out_valid`=1. On `out_valid`&`out_ready`: if index = NUM_PE-1 go IDLE, else index+1 and register that lane's result. No handshake → all outputs held stable.
- Per-lane arithmetic, width ACC_W+2, no intermediate overflow:
  - sum = sext(acc) + sext(bias)
  - if shift>0: sum += 1<<(shift-1) (round half up); r = sum >>> shift (arithmetic)
  - if relu_en and r<0: r = 0
  - saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-256, 255] at default
- `out_last` = EMIT and index = NUM_PE-1.
- `acc_valid` outside IDLE is ignored (not captured); upstream must hold it until `acc_ready`.
- Bank, shift and relu are frozen from capture until return to IDLE; input changes meanwhile have no effect.

## Timing
- Reset (rst_n low at a rising edge): state IDLE, `acc_ready`=1 after the edge; `out_valid`, `clr_acc`, `busy`, `out_last` = 0; `out_data`=0, `out_idx`=0. Applies mid-pass: pending channels are discarded, no `clr_acc` issued.
- Capture at edge E0 → LOAD cycle: `clr_acc`=1, `busy`=1, `acc_ready`=0; PE clears at E1.
- Lane 0 valid after E1 (latency 2 edges from capture to first `out_valid`).
- With `out_ready` constantly high: one channel per cycle, NUM_PE EMIT cycles, `acc_ready` high after the edge accepting the last channel; next capture possible that same cycle. Minimum pass period NUM_PE+2 cycles.
- `out_ready` may be high before `out_valid`; no combinational path from `out_ready` to `out_valid` or `acc_ready`.
- `clr_acc` is exactly one cycle per capture, never during reset.

## Test plan
- Rounding: lane0 acc=1000, bias=24, shift=3, relu off → out_data=128, idx 0; lane1 acc=12, bias=0 → 2; lane2 acc=-12, bias=0 → -1.
- Saturation/ReLU: acc=-5000, bias=0, shift=4, relu off → -256; same with relu on → 0; acc=100000, shift=0 → 255.
- Handshake/latency: capture at cycle 0 → `clr_acc` high cycle 1 only, `out_valid` from cycle 2, 8 channels idx 0..7 in cycles 2..9, `out_last` only on idx 7, `acc_ready` high cycle 10.
- Backpressure: drop `out_ready` for 5 cycles at idx 3 → idx 3 data held stable, no skipped/duplicated channel; toggling `acc_valid`/`acc_data` meanwhile changes nothing.
- Mid-pass reset: assert rst_n=0 at idx 4 → next cycle `out_valid`=0, `acc_ready`=1, `out_data`=0; a new capture yields a clean pass from idx 0.
- Back-to-back: `acc_valid` held high with new data → second pass captured the cycle `acc_ready` returns, second `clr_acc` pulse, results reflect second data set.
